bet_round_controller: RTL and testbench
=======================================

// Module: bet_round_controller
// PURPOSE
//  Sequences one roulette round: takes keyboard bet codes + Arduino chip colour into a 12-slot bet buffer,
//  starts a spin on the spin key, waits for the processor's result, holds it for display, then clears.
//  Sits between keyboard decode / colour sense and the register file, which reads bets and writes results.
// PARAMETERS
//  MAX_BETS      12         bet slots; 1..15
//  BET_W         8          slot width: {colour[1:0], opcode[5:0]}
//  SPIN_TIMEOUT  50_000_000 max cycles in WAIT_RESULT before abort
//  HOLD_CYCLES   100_000_000 cycles in SHOW before clear
// PORTS
//  clock          in   1          system clock
//  reset          in   1          synchronous, active-high
//  key_valid      in   1          level; high while decoded key byte valid (PS/2 read_data)
//  bet_opcode     in   6          decoded key; 6'b111111 = none, 6'b111110 = spin
//  chip_color     in   3          Arduino chip colour; 3'b000 = no chip present
//  result_valid   in   1          one-cycle pulse from processor: spin result ready
//  result_number  in   6          winning pocket 0..36, sampled with result_valid
//  bets_flat      out  MAX_BETS*BET_W  slot i at [i*BET_W +: BET_W]; empty slot = 0
//  bet_count      out  4          occupied slots
//  spin_req       out  1          one-cycle pulse to processor: start spin
//  bets_locked    out  1          high outside COLLECT
//  win_number     out  6          latched result, valid in SHOW
//  win_valid      out  1          high in SHOW
//  reject         out  1          one-cycle pulse: key event refused
//  round_state    out  3          COLLECT=0 SPIN=1 WAIT_RESULT=2 SHOW=3 CLEAR=4
// BEHAVIOUR
//  - reset: state COLLECT; all slots, bet_count, win_number = 0; all pulses/flags low.
//  - key event = rising edge of key_valid (registered; one event per assertion). Held key never repeats.
//  - COLLECT, key event:
//    opcode 111111 -> ignored, no reject.  opcode 111110 -> count==0: reject; else SPIN next cycle.
//    other opcode: chip_color==000 or count==MAX_BETS -> reject, buffer unchanged;
//    else slot[count] <= {chip_color[1:0], opcode}, count+1; visible on bets_flat next cycle.
//  - SPIN: spin_req=1 for exactly this one cycle; -> WAIT_RESULT; timeout counter cleared.
//  - WAIT_RESULT: result_valid -> latch win_number, -> SHOW. Counter reaching SPIN_TIMEOUT-1 -> CLEAR,
//    win_valid never asserted. result_valid in any other state ignored.
//  - SHOW: win_valid=1 for HOLD_CYCLES cycles, then CLEAR.
//  - CLEAR: one cycle; zero all slots and count, win_number kept; -> COLLECT.
//  - key events outside COLLECT: any non-111111 opcode -> reject pulse, no state change.
//  - result_valid coinciding with timeout terminal cycle: result wins (-> SHOW).
//  - reset mid-round (any state): immediate return to reset values next edge; no spin_req issued.
//  - bets_locked = (state != COLLECT). reject asserted the cycle after the key event.
// CONFIGURATION
//  BET_UNDO_EN defined: opcode 6'b111101 in COLLECT removes last bet (slot[count-1] <= 0, count-1);
//    count==0 -> reject. Outside COLLECT -> reject.
//  BET_UNDO_EN undefined: 111101 treated as an ordinary bet opcode.
// TESTING
//  T1 reset, then key edges opcode 6'd5 colour 3'b001, 6'd17 colour 3'b010 -> count=2,
//     slot0=8'h45, slot1=8'h91, no reject.
//  T2 COLLECT, count=0, spin key -> reject pulse, round_state stays 0, no spin_req.
//  T3 2 bets, spin key -> spin_req one cycle, state 1->2; result_valid with 6'd23 -> win_number=23,
//     win_valid for HOLD_CYCLES (bench HOLD_CYCLES=8), then CLEAR, count=0, bets_flat=0.
//  T4 fill 12 bets, 13th bet -> reject, slot12 untouched; bet key during WAIT_RESULT -> reject.
//  T5 key_valid held high 20 cycles with valid bet -> exactly one bet stored; colour 000 -> reject.
//  T6 WAIT_RESULT with no result (SPIN_TIMEOUT=16) -> CLEAR at cycle 16, win_valid never high;
//     reset asserted in SHOW -> all outputs at reset values next cycle; BET_UNDO_EN: undo after 3 bets -> count 2.

Source files
------------

// File: rtl/bet_round_controller.sv
// bet_round_controller
// Sequences one roulette round: collects keyboard bet codes tagged with the
// sensed chip colour into a small bet buffer, issues a spin request, waits for
// the processor's result, holds the result for display, then clears the table.
//
// Optional feature macro: BET_UNDO_EN
//   defined   -> opcode 6'b111101 removes the most recent bet while collecting
//   undefined -> 6'b111101 is stored like any other bet opcode
module bet_round_controller #(
    parameter int MAX_BETS     = 12,
    parameter int BET_W        = 8,
    parameter int SPIN_TIMEOUT = 50_000_000,
    parameter int HOLD_CYCLES  = 100_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [5:0]                bet_opcode,
    input  logic [2:0]                chip_color,
    input  logic                      result_valid,
    input  logic [5:0]                result_number,
    output logic [MAX_BETS*BET_W-1:0] bets_flat,
    output logic [3:0]                bet_count,
    output logic                      spin_req,
    output logic                      bets_locked,
    output logic [5:0]                win_number,
    output logic                      win_valid,
    output logic                      reject,
    output logic [2:0]                round_state
);

    localparam int TO_W = (SPIN_TIMEOUT > 1) ? $clog2(SPIN_TIMEOUT) : 1;
    localparam int HO_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(SPIN_TIMEOUT - 1);
    localparam logic [HO_W-1:0] HO_LAST   = HO_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      MAX_COUNT = 4'(MAX_BETS);

    localparam logic [5:0] OP_NONE = 6'b111111;
    localparam logic [5:0] OP_SPIN = 6'b111110;
    localparam logic [5:0] OP_UNDO = 6'b111101;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_SPIN    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    state_t          state_reg;
    logic            key_valid_reg;
    logic [3:0]      bet_count_reg;
    logic [TO_W-1:0] timeout_cnt_reg;
    logic [HO_W-1:0] hold_cnt_reg;
    logic [5:0]      win_number_reg;
    logic            win_valid_reg;
    logic            spin_req_reg;
    logic            reject_reg;

    logic             key_event;
    logic             in_collect;
    logic             op_none;
    logic             op_spin;
    logic             op_undo;
    logic             bet_accept;
    logic             spin_accept;
    logic             reject_next;
    logic             clear_all;
    logic [BET_W-1:0] new_bet;
`ifdef BET_UNDO_EN
    logic             undo_accept;
`endif

    // Decode the key event and decide whether it is accepted or refused
    always_comb begin
        key_event   = key_valid & ~key_valid_reg;
        in_collect  = (state_reg == ST_COLLECT);
        op_none     = (bet_opcode == OP_NONE);
        op_spin     = (bet_opcode == OP_SPIN);
`ifdef BET_UNDO_EN
        op_undo     = (bet_opcode == OP_UNDO);
        undo_accept = key_event & in_collect & op_undo & (bet_count_reg != 4'd0);
`else
        op_undo     = 1'b0;
`endif
        bet_accept  = key_event & in_collect & ~op_none & ~op_spin & ~op_undo
                      & (chip_color != 3'b000) & (bet_count_reg != MAX_COUNT);
        spin_accept = key_event & in_collect & op_spin & (bet_count_reg != 4'd0);
        reject_next = key_event & ~op_none & ~bet_accept & ~spin_accept;
`ifdef BET_UNDO_EN
        reject_next = reject_next & ~undo_accept;
`endif
        clear_all   = (state_reg == ST_CLEAR);
        new_bet     = BET_W'({chip_color[1:0], bet_opcode});
    end

    // Round sequencer: state, bet count, timers and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_COLLECT;
            key_valid_reg   <= 1'b0;
            bet_count_reg   <= 4'd0;
            timeout_cnt_reg <= '0;
            hold_cnt_reg    <= '0;
            win_number_reg  <= 6'd0;
            win_valid_reg   <= 1'b0;
            spin_req_reg    <= 1'b0;
            reject_reg      <= 1'b0;
        end else begin
            key_valid_reg <= key_valid;
            reject_reg    <= reject_next;
            spin_req_reg  <= 1'b0;
            case (state_reg)
                ST_COLLECT: begin
                    if (bet_accept) begin
                        bet_count_reg <= bet_count_reg + 4'd1;
`ifdef BET_UNDO_EN
                    end else if (undo_accept) begin
                        bet_count_reg <= bet_count_reg - 4'd1;
`endif
                    end else if (spin_accept) begin
                        state_reg    <= ST_SPIN;
                        spin_req_reg <= 1'b1;
                    end
                end
                ST_SPIN: begin
                    state_reg       <= ST_WAIT;
                    timeout_cnt_reg <= '0;
                end
                ST_WAIT: begin
                    // A result arriving on the terminal timeout cycle still counts
                    if (result_valid) begin
                        win_number_reg <= result_number;
                        win_valid_reg  <= 1'b1;
                        hold_cnt_reg   <= '0;
                        state_reg      <= ST_SHOW;
                    end else if (timeout_cnt_reg == TO_LAST) begin
                        state_reg <= ST_CLEAR;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (hold_cnt_reg == HO_LAST) begin
                        win_valid_reg <= 1'b0;
                        state_reg     <= ST_CLEAR;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    bet_count_reg <= 4'd0;
                    state_reg     <= ST_COLLECT;
                end
                default: begin
                    state_reg <= ST_COLLECT;
                end
            endcase
        end
    end

    // One register per bet slot; slot index equals the count at write time
    genvar gi;
    generate
        for (gi = 0; gi < MAX_BETS; gi++) begin : g_slot
            logic [BET_W-1:0] slot_reg;

            // Store, undo or wipe this slot
            always_ff @(posedge clock) begin
                if (reset || clear_all) begin
                    slot_reg <= '0;
                end else if (bet_accept && (bet_count_reg == 4'(gi))) begin
                    slot_reg <= new_bet;
`ifdef BET_UNDO_EN
                end else if (undo_accept && (bet_count_reg == 4'(gi + 1))) begin
                    slot_reg <= '0;
`endif
                end
            end

            assign bets_flat[gi*BET_W +: BET_W] = slot_reg;
        end
    endgenerate

    assign bet_count   = bet_count_reg;
    assign spin_req    = spin_req_reg;
    assign bets_locked = (state_reg != ST_COLLECT);
    assign win_number  = win_number_reg;
    assign win_valid   = win_valid_reg;
    assign reject      = reject_reg;
    assign round_state = state_reg;

endmodule

// File: tb/tb_bet_round_controller.sv
// Bench for bet_round_controller: a queue-based round model checked against
// the DUT every cycle, plus directed scenarios with literal expectations.
module tb_bet_round_controller;

    localparam int MAX_BETS     = 12;
    localparam int BET_W        = 8;
    localparam int SPIN_TIMEOUT = 16;
    localparam int HOLD_CYCLES  = 8;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      key_valid;
    logic [5:0]                bet_opcode;
    logic [2:0]                chip_color;
    logic                      result_valid;
    logic [5:0]                result_number;
    logic [MAX_BETS*BET_W-1:0] bets_flat;
    logic [3:0]                bet_count;
    logic                      spin_req;
    logic                      bets_locked;
    logic [5:0]                win_number;
    logic                      win_valid;
    logic                      reject;
    logic [2:0]                round_state;

    bet_round_controller #(
        .MAX_BETS(MAX_BETS), .BET_W(BET_W),
        .SPIN_TIMEOUT(SPIN_TIMEOUT), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid),
        .bet_opcode(bet_opcode), .chip_color(chip_color),
        .result_valid(result_valid), .result_number(result_number),
        .bets_flat(bets_flat), .bet_count(bet_count), .spin_req(spin_req),
        .bets_locked(bets_locked), .win_number(win_number), .win_valid(win_valid),
        .reject(reject), .round_state(round_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Round phase: 0 collect, 1 spin, 2 waiting, 3 showing, 4 clearing
    int         m_phase = 0;
    logic [7:0] m_bets[$];
    int         m_waited = 0;
    int         m_shown = 0;
    bit         m_prev_key = 0;
    bit         m_reject = 0;
    logic [5:0] m_win = 6'd0;
    bit         started = 0;

    always @(posedge clock) begin : model
        int  cur;
        bit  ev;
        if (reset) begin
            m_phase = 0; m_bets.delete(); m_waited = 0; m_shown = 0;
            m_prev_key = 0; m_reject = 0; m_win = 6'd0;
        end else begin
            cur = m_phase;
            ev = key_valid && !m_prev_key;
            m_prev_key = key_valid;
            m_reject = 0;
            if (ev && bet_opcode != 6'h3F) begin
                if (cur != 0) m_reject = 1;
                else if (bet_opcode == 6'h3E) begin
                    if (m_bets.size() == 0) m_reject = 1;
                    else m_phase = 1;
                end
`ifdef BET_UNDO_EN
                else if (bet_opcode == 6'h3D) begin
                    if (m_bets.size() == 0) m_reject = 1;
                    else void'(m_bets.pop_back());
                end
`endif
                else if (chip_color == 3'b000 || m_bets.size() == MAX_BETS) m_reject = 1;
                else m_bets.push_back({chip_color[1:0], bet_opcode});
            end
            case (cur)
                1: begin m_phase = 2; m_waited = 0; end
                2: begin
                    if (result_valid) begin
                        m_win = result_number; m_phase = 3; m_shown = 0;
                    end else begin
                        m_waited++;
                        if (m_waited == SPIN_TIMEOUT) m_phase = 4;
                    end
                end
                3: begin
                    m_shown++;
                    if (m_shown == HOLD_CYCLES) m_phase = 4;
                end
                4: begin m_bets.delete(); m_phase = 0; end
                default: ;
            endcase
        end
        started = 1;
    end

    // Compare every output with the model on each falling edge
    always @(negedge clock) begin : compare
        logic [MAX_BETS*BET_W-1:0] exp_flat;
        if (started) begin
            exp_flat = '0;
            for (int i = 0; i < m_bets.size(); i++) exp_flat[i*BET_W +: BET_W] = m_bets[i];
            chk("model bets_flat", bets_flat, exp_flat);
            chk("model bet_count", bet_count, m_bets.size());
            chk("model round_state", round_state, m_phase);
            chk("model spin_req", spin_req, m_phase == 1);
            chk("model bets_locked", bets_locked, m_phase != 0);
            chk("model win_valid", win_valid, m_phase == 3);
            chk("model win_number", win_number, m_win);
            chk("model reject", reject, m_reject);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    // One key press: rising edge for one cycle, then released
    task automatic press(input logic [5:0] op, input logic [2:0] col,
                         output logic rej, output logic [2:0] st, output logic sp);
        bet_opcode = op; chip_color = col; key_valid = 1'b1;
        tick();
        rej = reject; st = round_state; sp = spin_req;
        key_valid = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] target, input int bound, input string name);
        for (int k = 0; k < bound && round_state != target; k++) tick();
        chk(name, round_state, target);
    endtask

    initial begin : stim
        logic       rej, sp;
        logic [2:0] st;
        logic [MAX_BETS*BET_W-1:0] saved;
        int n, rj;
        bit seen;

        reset = 1'b1; key_valid = 1'b0; bet_opcode = 6'h3F; chip_color = 3'b000;
        result_valid = 1'b0; result_number = 6'd0;
        repeat (3) tick();
        chk("reset state", round_state, 3'd0);
        chk("reset count", bet_count, 4'd0);
        chk("reset flat", bets_flat, 0);
        chk("reset flags", {spin_req, win_valid, reject, bets_locked}, 4'b0000);
        reset = 1'b0;
        tick();

        // T2: spin with empty table
        press(6'h3E, 3'b001, rej, st, sp);
        chk("T2 reject", rej, 1'b1);
        chk("T2 state", st, 3'd0);
        chk("T2 spin_req", sp, 1'b0);

        // T1: two bets
        press(6'd5, 3'b001, rej, st, sp);
        chk("T1 bet0 reject", rej, 1'b0);
        press(6'd17, 3'b010, rej, st, sp);
        chk("T1 bet1 reject", rej, 1'b0);
        chk("T1 count", bet_count, 4'd2);
        chk("T1 slot0", bets_flat[7:0], 8'h45);
        chk("T1 slot1", bets_flat[15:8], 8'h91);

        // T3: spin, result, hold, clear
        press(6'h3E, 3'b000, rej, st, sp);
        chk("T3 spin reject", rej, 1'b0);
        chk("T3 spin state", st, 3'd1);
        chk("T3 spin_req", sp, 1'b1);
        chk("T3 wait state", round_state, 3'd2);
        chk("T3 spin_req drop", spin_req, 1'b0);
        result_valid = 1'b1; result_number = 6'd23;
        tick();
        result_valid = 1'b0;
        chk("T3 show state", round_state, 3'd3);
        chk("T3 win_number", win_number, 6'd23);
        n = win_valid ? 1 : 0;
        for (int k = 0; k < 40 && win_valid; k++) begin
            tick();
            if (win_valid) n++;
        end
        chk("T3 hold cycles", n, HOLD_CYCLES);
        chk("T3 clear state", round_state, 3'd4);
        tick();
        chk("T3 collect state", round_state, 3'd0);
        chk("T3 count cleared", bet_count, 4'd0);
        chk("T3 flat cleared", bets_flat, 0);
        chk("T3 win kept", win_number, 6'd23);

        // T4: fill the table, overflow, bet while waiting
        rj = 0;
        for (int i = 0; i < MAX_BETS; i++) begin
            press(6'(i + 1), 3'(i % 3 + 1), rej, st, sp);
            if (rej) rj++;
        end
        chk("T4 fill rejects", rj, 0);
        chk("T4 full count", bet_count, 4'd12);
        chk("T4 slot11", bets_flat[95:88], 8'hCC);
        saved = bets_flat;
        press(6'd40, 3'b001, rej, st, sp);
        chk("T4 overflow reject", rej, 1'b1);
        chk("T4 overflow untouched", bets_flat, saved);
        chk("T4 overflow count", bet_count, 4'd12);
        press(6'h3E, 3'b000, rej, st, sp);
        chk("T4 spin_req", sp, 1'b1);
        press(6'd7, 3'b001, rej, st, sp);
        chk("T4 locked reject", rej, 1'b1);
        chk("T4 locked state", st, 3'd2);
        result_valid = 1'b1; result_number = 6'd9;
        tick();
        result_valid = 1'b0;
        wait_state(3'd0, 50, "T4 round end");

        // T5: held key gives one bet; no-chip bet refused
        bet_opcode = 6'd9; chip_color = 3'b011; key_valid = 1'b1;
        rj = 0;
        repeat (20) begin
            tick();
            if (reject) rj++;
        end
        key_valid = 1'b0;
        tick();
        chk("T5 held count", bet_count, 4'd1);
        chk("T5 held rejects", rj, 0);
        chk("T5 held slot0", bets_flat[7:0], 8'hC9);
        press(6'd10, 3'b000, rej, st, sp);
        chk("T5 no chip reject", rej, 1'b1);
        chk("T5 no chip count", bet_count, 4'd1);

        // T6: timeout without result
        press(6'h3E, 3'b000, rej, st, sp);
        n = (round_state == 3'd2) ? 1 : 0;
        seen = 0;
        for (int k = 0; k < 100 && round_state == 3'd2; k++) begin
            tick();
            if (win_valid) seen = 1;
            if (round_state == 3'd2) n++;
        end
        chk("T6 wait cycles", n, SPIN_TIMEOUT);
        chk("T6 timeout state", round_state, 3'd4);
        chk("T6 no win_valid", seen, 1'b0);
        tick();
        chk("T6 cleared count", bet_count, 4'd0);

        // T6: reset while showing a result
        press(6'd1, 3'b001, rej, st, sp);
        press(6'h3E, 3'b000, rej, st, sp);
        result_valid = 1'b1; result_number = 6'd30;
        tick();
        result_valid = 1'b0;
        tick(); tick();
        chk("T6 show before reset", win_valid, 1'b1);
        reset = 1'b1;
        tick();
        chk("T6 reset state", round_state, 3'd0);
        chk("T6 reset win", {win_valid, win_number}, 7'd0);
        chk("T6 reset count", bet_count, 4'd0);
        chk("T6 reset flat", bets_flat, 0);
        chk("T6 reset pulses", {spin_req, reject, bets_locked}, 3'b000);
        reset = 1'b0;
        tick();

        // Undo opcode behaviour
`ifdef BET_UNDO_EN
        press(6'd2, 3'b001, rej, st, sp);
        press(6'd3, 3'b010, rej, st, sp);
        press(6'd4, 3'b011, rej, st, sp);
        press(6'h3D, 3'b001, rej, st, sp);
        chk("undo reject", rej, 1'b0);
        chk("undo count", bet_count, 4'd2);
        chk("undo slot2", bets_flat[23:16], 8'h00);
`else
        press(6'h3D, 3'b001, rej, st, sp);
        chk("3D as bet reject", rej, 1'b0);
        chk("3D as bet count", bet_count, 4'd1);
        chk("3D as bet slot0", bets_flat[7:0], 8'h7D);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
